// File: rtl/mf_trig_pkg.sv
// Shared definitions for the matched-filter peak trigger.
// Contents:
//   - state encoding constants and the FSM state enum
//   - legal range of the peak-search window length
package mf_trig_pkg;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_ARMED_ENC   = 2'd1;
  localparam logic [1:0] ST_PEAK_ENC    = 2'd2;
  localparam logic [1:0] ST_HOLDOFF_ENC = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE_ENC,
    S_ARMED   = ST_ARMED_ENC,
    S_PEAK    = ST_PEAK_ENC,
    S_HOLDOFF = ST_HOLDOFF_ENC
  } state_e;

  localparam int unsigned PEAK_WIN_MIN = 2;
  localparam int unsigned PEAK_WIN_MAX = 255;

endpackage

// File: rtl/mf_abs_sat.sv
// Registered saturating absolute value (one clock latency).
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   x_i    - two's-complement input, W bits
//   mag_o  - |x_i| in W-1 bits; the most negative input saturates to all ones
module mf_abs_sat #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] x_i,
  output logic [W-2:0] mag_o
);

  logic [W-2:0] mag_d;
  logic [W-2:0] mag_q;

  // For any negative value other than the minimum, the negation fits in W-1
  // bits, so only the low bits of ~x+1 are needed.
  always_comb begin
    mag_d = x_i[W-2:0];
    if (x_i[W-1]) begin
      if (x_i[W-2:0] == '0) mag_d = '1;
      else                  mag_d = (~x_i[W-2:0]) + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mag_q <= '0;
    else         mag_q <= mag_d;
  end

  assign mag_o = mag_q;

endmodule

// File: rtl/mf_peak_trigger.sv
// Peak trigger behind the matched filter. Two signed samples per clock are
// turned into saturated magnitudes, the larger of each pair is compared to a
// threshold, and the first crossing opens a PEAK_WIN-clock search window whose
// maximum (with its sample index {ts, lane}) is reported with a one-clock
// trigger pulse. A programmable holdoff follows before re-arming.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   in0_i, in1_i       - signed filter outputs, lane 0 earlier than lane 1
//   enable_i           - level arm; low forces IDLE and discards a window
//   threshold_i        - unsigned magnitude threshold (strictly-greater test)
//   holdoff_i          - holdoff length, latched when the trigger fires
//   trig_o             - one-clock trigger pulse
//   trig_peak_o        - window maximum magnitude, held
//   trig_time_o        - sample index of the peak, {ts, lane}, held
//   trig_count_o       - wrapping trigger count
//   state_o            - current FSM state
module mf_peak_trigger
  import mf_trig_pkg::*;
#(
  parameter int unsigned INBITS   = 16,
  parameter int unsigned TSBITS   = 32,
  parameter int unsigned PEAK_WIN = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [INBITS-1:0] in0_i,
  input  logic [INBITS-1:0] in1_i,
  input  logic              enable_i,
  input  logic [INBITS-2:0] threshold_i,
  input  logic [15:0]       holdoff_i,
  output logic              trig_o,
  output logic [INBITS-2:0] trig_peak_o,
  output logic [TSBITS:0]   trig_time_o,
  output logic [15:0]       trig_count_o,
  output logic [1:0]        state_o
);

  localparam int unsigned MW       = INBITS - 1;
  localparam logic [7:0]  WIN_LAST = 8'(PEAK_WIN - 1);

  if (PEAK_WIN < PEAK_WIN_MIN || PEAK_WIN > PEAK_WIN_MAX) begin : g_bad_win
    $error("mf_peak_trigger: PEAK_WIN out of legal range");
  end

  // Free-running timestamp and its copy travelling with stage 1.
  logic [TSBITS-1:0] ts_q;
  logic [TSBITS-1:0] ts1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q  <= '0;
      ts1_q <= '0;
    end else begin
      ts_q  <= ts_q + 1'b1;
      ts1_q <= ts_q;
    end
  end

  // Stage 1: saturated magnitudes.
  logic [MW-1:0] mag0;
  logic [MW-1:0] mag1;

  mf_abs_sat #(.W(INBITS)) u_abs0 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .x_i    (in0_i),
    .mag_o  (mag0)
  );

  mf_abs_sat #(.W(INBITS)) u_abs1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .x_i    (in1_i),
    .mag_o  (mag1)
  );

  // Stage 2: pair maximum (lane 0 wins ties) and threshold test.
  logic              lane_d;
  logic [MW-1:0]     pmax_d;
  logic              above_d;
  logic [MW-1:0]     pmax_q;
  logic              plane_q;
  logic [TSBITS-1:0] pts_q;
  logic              above_q;

  always_comb begin
    lane_d  = (mag1 > mag0);
    pmax_d  = lane_d ? mag1 : mag0;
    above_d = (pmax_d > threshold_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pmax_q  <= '0;
      plane_q <= 1'b0;
      pts_q   <= '0;
      above_q <= 1'b0;
    end else begin
      pmax_q  <= pmax_d;
      plane_q <= lane_d;
      pts_q   <= ts1_q;
      above_q <= above_d;
    end
  end

  // Window running max including the current stage-2 pair; strictly greater
  // replaces, so the earliest sample keeps ties.
  state_e          state_q;
  logic [MW-1:0]   wmax_q;
  logic [TSBITS:0] widx_q;
  logic [7:0]      win_cnt_q;
  logic [15:0]     hold_q;
  logic            trig_q;
  logic [MW-1:0]   peak_q;
  logic [TSBITS:0] time_q;
  logic [15:0]     count_q;
  logic [MW-1:0]   wmax_d;
  logic [TSBITS:0] widx_d;

  always_comb begin
    wmax_d = wmax_q;
    widx_d = widx_q;
    if (pmax_q > wmax_q) begin
      wmax_d = pmax_q;
      widx_d = {pts_q, plane_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      wmax_q    <= '0;
      widx_q    <= '0;
      win_cnt_q <= '0;
      hold_q    <= '0;
      trig_q    <= 1'b0;
      peak_q    <= '0;
      time_q    <= '0;
      count_q   <= '0;
    end else begin
      trig_q <= 1'b0;
      if (!enable_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_ARMED;
          S_ARMED: begin
            if (above_q) begin
              wmax_q    <= pmax_q;
              widx_q    <= {pts_q, plane_q};
              win_cnt_q <= 8'd1;
              state_q   <= S_PEAK;
            end
          end
          S_PEAK: begin
            if (win_cnt_q == WIN_LAST) begin
              trig_q  <= 1'b1;
              peak_q  <= wmax_d;
              time_q  <= widx_d;
              count_q <= count_q + 16'd1;
              hold_q  <= holdoff_i;
              state_q <= S_HOLDOFF;
            end else begin
              wmax_q    <= wmax_d;
              widx_q    <= widx_d;
              win_cnt_q <= win_cnt_q + 8'd1;
            end
          end
          S_HOLDOFF: begin
            if (hold_q == '0) state_q <= S_ARMED;
            else              hold_q  <= hold_q - 16'd1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign trig_o       = trig_q;
  assign trig_peak_o  = peak_q;
  assign trig_time_o  = time_q;
  assign trig_count_o = count_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mf_peak_trigger.sv
module tb_mf_peak_trigger;

  localparam int PW   = 4;
  localparam int MAXC = 8192;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] in0, in1;
  logic               en;
  logic [14:0]        thr;
  logic [15:0]        hold;
  logic               trig;
  logic [14:0]        tpeak;
  logic [32:0]        ttime;
  logic [15:0]        tcount;
  logic [1:0]         st;

  mf_peak_trigger #(.INBITS(16), .TSBITS(32), .PEAK_WIN(PW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in0_i        (in0),
    .in1_i        (in1),
    .enable_i     (en),
    .threshold_i  (thr),
    .holdoff_i    (hold),
    .trig_o       (trig),
    .trig_peak_o  (tpeak),
    .trig_time_o  (ttime),
    .trig_count_o (tcount),
    .state_o      (st)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  // Recorded input history, indexed by cycle since reset release.
  int h0[MAXC], h1[MAXC], hthr[MAXC], hhold[MAXC];
  bit hen[MAXC];
  int cyc;

  // Reference model: mode 0 idle, 1 armed, 2 window open, 3 holdoff.
  int          mmode, ws, hleft;
  bit          e_trig;
  int          e_peak;
  logic [32:0] e_time;
  logic [15:0] e_count;

  function automatic int magf(int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m > 32767) m = 32767;
    return m;
  endfunction

  function automatic int pmaxf(int c);
    int a, b;
    a = magf(h0[c]);
    b = magf(h1[c]);
    return (a > b) ? a : b;
  endfunction

  // Decision made at the edge closing cycle d, for the pair presented in d-2.
  task automatic model_step(int d);
    int p, best, bidx, m;
    p = d - 2;
    e_trig = 1'b0;
    if (!hen[d]) mmode = 0;
    else begin
      case (mmode)
        0: mmode = 1;
        1: if (p >= 0 && pmaxf(p) > hthr[d-1]) begin ws = p; mmode = 2; end
        2: if (p - ws + 1 == PW) begin
             best = -1; bidx = 0;
             for (int c = ws; c < ws + PW; c++) begin
               m = magf(h0[c]); if (m > best) begin best = m; bidx = 2*c; end
               m = magf(h1[c]); if (m > best) begin best = m; bidx = 2*c + 1; end
             end
             e_trig = 1'b1; e_peak = best; e_time = 33'(bidx);
             e_count = e_count + 16'd1; hleft = hhold[d]; mmode = 3;
           end
        default: if (hleft == 0) mmode = 1; else hleft--;
      endcase
    end
  endtask

  task automatic chk(string name, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model();
    nvec++;
    if (trig !== e_trig || (tpeak !== 15'(e_peak)) || ttime !== e_time ||
        tcount !== e_count || st !== 2'(mmode)) begin
      nfail++;
      $display("FAIL model cyc %0d: got trig=%0b peak=%0d time=%0d cnt=%0d st=%0d expected trig=%0b peak=%0d time=%0d cnt=%0d st=%0d",
               cyc, trig, tpeak, ttime, tcount, st, e_trig, e_peak, e_time, e_count, mmode);
    end
  endtask

  task automatic tick();
    if (cyc >= MAXC - 1) begin
      $display("FAIL history overflow at cycle %0d", cyc);
      $fatal(1, "history overflow");
    end
    h0[cyc] = int'(in0); h1[cyc] = int'(in1); hen[cyc] = en;
    hthr[cyc] = int'(thr); hhold[cyc] = int'(hold);
    @(posedge clk);
    model_step(cyc);
    cyc++;
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in0 = '0; in1 = '0;
    #2;
    chk("reset_outputs", {trig, tpeak, ttime, tcount}, 0);
    chk("reset_state", st, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; mmode = 0; ws = 0; hleft = 0;
    e_trig = 0; e_peak = 0; e_time = '0; e_count = '0;
  endtask

  typedef struct {
    string name;
    int    start;
    int    a0[5];
    int    a1[5];
    bit    exp_trig;
    int    exp_peak;
    int    exp_time;
  } row_t;

  row_t rows[7];
  int pulses, tcyc, pk, tm, T, n_after;

  initial begin
    rst_n = 1'b0; in0 = '0; in1 = '0; en = 1'b0; thr = 15'd1000; hold = '0;
    cyc = 0; mmode = 0; e_count = '0; e_time = '0; e_peak = 0; e_trig = 0;

    rows[0] = '{"single",   10, '{0,0,0,0,0},         '{1500,0,0,0,0},    1, 1500, 21};
    rows[1] = '{"sat",      10, '{-32768,0,0,0,0},    '{0,0,0,0,0},       1, 32767, 20};
    rows[2] = '{"tie",      20, '{0,2000,0,0,0},      '{2000,0,0,0,0},    1, 2000, 41};
    rows[3] = '{"window",   30, '{1100,0,2500,0,0},   '{0,3000,0,0,5000}, 1, 3000, 63};
    rows[4] = '{"negative", 10, '{-1200,0,0,0,0},     '{1199,0,0,0,0},    1, 1200, 20};
    rows[5] = '{"at_thr",   10, '{1000,0,0,0,0},      '{-1000,0,0,0,0},   0, 0, 0};
    rows[6] = '{"above_thr",10, '{0,0,0,0,0},         '{1001,0,0,0,0},    1, 1001, 21};

    // Table-driven scenarios.
    for (int r = 0; r < 7; r++) begin
      en = 1'b0;
      do_reset();
      en = 1'b1; thr = 15'd1000; hold = '0;
      pulses = 0; tcyc = -1; pk = 0; tm = 0;
      for (int k = 0; k <= rows[r].start + 12; k++) begin
        if (k >= rows[r].start && k < rows[r].start + 5) begin
          in0 = 16'(rows[r].a0[k - rows[r].start]);
          in1 = 16'(rows[r].a1[k - rows[r].start]);
        end else begin
          in0 = '0; in1 = '0;
        end
        tick();
        if (trig) begin pulses++; tcyc = cyc; pk = int'(tpeak); tm = int'(ttime); end
      end
      chk({rows[r].name, "_pulses"}, pulses, rows[r].exp_trig ? 1 : 0);
      if (rows[r].exp_trig) begin
        chk({rows[r].name, "_peak"}, pk, rows[r].exp_peak);
        chk({rows[r].name, "_time"}, tm, rows[r].exp_time);
        chk({rows[r].name, "_latency"}, tcyc, rows[r].start + 6);
      end
    end

    // Reset mid-window, then stay idle with enable low.
    for (int k = 0; k < 13; k++) begin
      in0 = (k == 10) ? 16'sd4000 : 16'sd0; in1 = '0;
      tick();
    end
    chk("midwin_state_peak", st, 2);
    en = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    chk("idle_after_reset", st, 0);
    chk("count_after_reset", tcount, 0);

    // Holdoff: spike at T+3 ignored, spike at T+8 triggers.
    en = 1'b1; thr = 15'd1000; hold = 16'd5;
    T = -1;
    for (int k = 0; k < 40 && T < 0; k++) begin
      in0 = '0; in1 = (cyc == 10) ? 16'sd1500 : 16'sd0;
      tick();
      if (trig) T = cyc;
    end
    chk("holdoff_first_trig", T, 16);
    if (T < 0) T = 16;
    n_after = 0; tcyc = -1;
    while (cyc < T + 26) begin
      in0 = (cyc == T + 3) ? 16'sd2000 : 16'sd0;
      in1 = (cyc == T + 8) ? 16'sd1800 : 16'sd0;
      tick();
      if (trig) begin n_after++; tcyc = cyc; end
    end
    chk("holdoff_pulses", n_after, 1);
    chk("holdoff_second_cycle", tcyc, T + 14);
    chk("holdoff_count", tcount, 2);
    chk("holdoff_peak", tpeak, 1800);

    // Enable drop on the window-completion edge, then re-enable.
    do_reset();
    en = 1'b1; hold = '0;
    pulses = 0;
    while (cyc < 60) begin
      in0 = '0;
      in1 = (cyc == 10 || cyc == 30 || cyc == 45) ? 16'sd1500 : 16'sd0;
      en  = (cyc == 35) ? 1'b0 : 1'b1;
      tick();
      if (trig && cyc > 20 && cyc < 45) pulses++;
      if (cyc == 36) chk("drop_state_idle", st, 0);
      if (cyc == 44) chk("drop_count_held", tcount, 1);
    end
    chk("drop_no_pulse", pulses, 0);
    chk("reenable_count", tcount, 2);
    chk("reenable_time", ttime, 91);

    // Randomized stream against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      en   = ($urandom_range(99) < 97);
      thr  = 15'($urandom_range(3000, 500));
      hold = 16'($urandom_range(7));
      if ($urandom_range(9) < 8) begin
        in0 = 16'($signed($urandom_range(1800)) - 900);
        in1 = 16'($signed($urandom_range(1800)) - 900);
      end else begin
        in0 = 16'($urandom);
        in1 = 16'($urandom);
      end
      if ($urandom_range(199) == 0) begin
        in0 = 16'sh8000;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mf_peak_trigger.md
# mf_peak_trigger

Downstream consumer of the systolic matched-filter stage. It takes the two 16-bit signed filter outputs produced each clock (two samples per clock, lane 0 earlier in time) and computes saturated magnitudes. It opens a fixed-length peak-search window on the first above-threshold sample and reports the window maximum with a sample-index timestamp. A programmable holdoff then re-arms the block. The result feeds the trigger/readout logic.

## Interface
Parameters:
- INBITS, 16, width of each signed filter output; matches filter output width.
- TSBITS, 32, width of the free-running clock-count timestamp.
- PEAK_WIN, 4, peak-search window length in clocks (sample pairs); legal range 2..255.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- in0_i  in  INBITS  filter output, lane 0 (earlier sample), signed.
- in1_i  in  INBITS  filter output, lane 1 (later sample), signed.
- enable_i  in  1  level arm; low forces IDLE.
- threshold_i  in  INBITS-1  unsigned magnitude threshold; sampled every clock.
- holdoff_i  in  16  holdoff length in clocks; latched when the trigger fires.
- trig_o  out  1  one-clock trigger pulse.
- trig_peak_o  out  INBITS-1  window maximum magnitude; held until the next trigger.
- trig_time_o  out  TSBITS+1  sample index of the peak, {ts, lane}; held.
- trig_count_o  out  16  triggers fired since reset; wraps.
- state_o  out  2  current FSM state, for debug.

## Operation
- Free-running ts counter, TSBITS wide, reset 0, +1 per clock, wraps. ts travels with each input pair through the pipeline; sample index = 2*ts + lane.
- S1 (register stage 1): mag = |x|, saturated. -2^(INBITS-1) maps to 2^(INBITS-1)-1.
- S2 (register stage 2):
  - pairmax = max(mag0, mag1); on a tie, lane 0 wins.
  - above = (pairmax > threshold_i), strictly greater.
- FSM states: IDLE=0, ARMED=1, PEAK=2, HOLDOFF=3.
  - IDLE → ARMED when enable_i = 1.
  - ARMED → PEAK when the S2 pair has above = 1. That pair loads the window max, its index and win_cnt = 1.
  - PEAK: each clock, compare the S2 pair against the max. Replace only if strictly greater, so the earliest sample wins ties. Threshold is ignored inside the window.
  - PEAK → HOLDOFF when win_cnt reaches PEAK_WIN on the same edge. On that edge:
    - register trig_o = 1;
    - update trig_peak_o and trig_time_o;
    - increment trig_count_o;
    - load hold_cnt = holdoff_i.
  - HOLDOFF: decrement hold_cnt each clock; → ARMED when hold_cnt = 0 at the edge. HOLDOFF lasts holdoff_i+1 clocks. All input is ignored.
  - Any state → IDLE when enable_i = 0. An open window is discarded: no trigger, outputs unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, ts 0, pipeline registers 0.
- Latency: for the first above-threshold pair captured at edge n, trig_o is high for exactly the clock following edge n+PEAK_WIN+1.
- The trig_peak_o, trig_time_o and trig_count_o updates are visible in the same cycle as trig_o.
- threshold_i changes apply to the pair in S2 at the next edge.
- enable_i low and window completion on the same edge: enable wins, no trigger.
- ts wrap: the index wraps modulo 2^(TSBITS+1) with no special handling.
- rst_ni asserted mid-window or mid-holdoff: immediate return to reset values; no pulse.

## Structure
- Package mf_trig_pkg holds:
  - the state enum typedef (IDLE, ARMED, PEAK, HOLDOFF);
  - the state encoding constants;
  - the PEAK_WIN legal-range constants.
- Sub-module mf_abs_sat: registered saturating absolute value, one clock. Instantiated once per lane.
- Everything else lives in the top: pair compare, FSM, counters.

## Test plan
Common settings: PEAK_WIN=4, threshold_i=1000.
- Reset: assert rst_ni low mid-stream → all outputs 0, state_o=0; after release with enable_i=0 → state stays IDLE.
- Single spike: in1_i=1500 at ts=10, others 0, holdoff_i=0 → one trig_o pulse in the cycle after edge 15; trig_peak_o=1500, trig_time_o=21, trig_count_o=1.
- Saturation and ties:
  - in0_i=-32768 → trig_peak_o=32767.
  - 2000 in lane 1 at ts=20 and lane 0 at ts=21, other samples in the window below 2000 → trig_time_o=41.
- Window max: pairs (1100,0), (0,3000), (2500,0), (0,0) starting at ts=30 → peak 3000, time 63. Another 5000 arriving at ts=34 (outside the window) → no effect on this trigger.
- Holdoff: holdoff_i=5.
  - Spike 3 clocks after the trig_o clock → ignored.
  - Spike 8 clocks after → second trigger, trig_count_o=2.
- Enable drop: enable_i deasserted during PEAK → no trig_o, state IDLE, trig_count_o unchanged. Re-enable plus a new spike triggers normally.
